// File: rtl/immed_gen_pipe_if.sv
// Handshake bundle for immed_gen_pipe.
// Handshake rule (both sides): a transfer happens on a rising clock edge
// where valid and ready are both 1; valid never waits on ready, and ready
// may be asserted without valid.
//   ir, in_valid / in_ready        : instruction word into the decoder
//   imm, fmt, illegal, out_valid /
//   out_ready                      : decoded entry at the buffer head
// Modports: master = producer of ir and consumer of the decoded entry,
//           slave  = the decoder block itself.
interface immed_gen_pipe_if #(
    parameter int XLEN = 32
);
    logic [31:0]     ir;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
    logic            out_valid;
    logic            out_ready;

    modport master (
        output ir, in_valid, out_ready,
        input  in_ready, imm, fmt, illegal, out_valid
    );

    modport slave (
        input  ir, in_valid, out_ready,
        output in_ready, imm, fmt, illegal, out_valid
    );
endinterface

// File: rtl/immed_gen_pipe.sv
// Immediate generator with a small output FIFO.
// Decodes the RISC-V opcode of each accepted instruction word into a format
// code (0=R/none, 1=I, 2=S, 3=B, 4=U, 5=J), a sign-extended immediate and an
// illegal flag, and buffers up to DEPTH results in order.
// Ports:
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset (drops all entries, clears ill_cnt)
//   flush   : synchronous clear of the buffer; wins over push and pop
//   bus     : immed_gen_pipe_if slave (ir/in_valid/in_ready in,
//             imm/fmt/illegal/out_valid/out_ready out)
//   ill_cnt : saturating count of accepted illegal opcodes (kept over flush)
module immed_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    immed_gen_pipe_if.slave       bus,
    output logic [CNT_W-1:0]      ill_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    // ---------------- decode ----------------
    logic [31:0]     dec_imm32;
    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_ill;

    always_comb begin
        dec_imm32 = '0;
        dec_fmt   = FMT_R;
        dec_ill   = 1'b0;
        case (bus.ir[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                dec_fmt   = FMT_I;
                dec_imm32 = {{20{bus.ir[31]}}, bus.ir[31:20]};
            end
            7'b0100011: begin
                dec_fmt   = FMT_S;
                dec_imm32 = {{20{bus.ir[31]}}, bus.ir[31:25], bus.ir[11:7]};
            end
            7'b1100011: begin
                dec_fmt   = FMT_B;
                dec_imm32 = {{19{bus.ir[31]}}, bus.ir[31], bus.ir[7],
                             bus.ir[30:25], bus.ir[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt   = FMT_U;
                dec_imm32 = {bus.ir[31:12], 12'b0};
            end
            7'b1101111: begin
                dec_fmt   = FMT_J;
                dec_imm32 = {{11{bus.ir[31]}}, bus.ir[31], bus.ir[19:12],
                             bus.ir[20], bus.ir[30:21], 1'b0};
            end
            7'b0110011: begin
                // R-type: no immediate, defaults already correct
            end
            default: dec_ill = 1'b1;
        endcase
    end

    // Every 32-bit result is already sign-correct, so widening to XLEN is a
    // plain sign extension (covers U format on 64-bit).
    assign dec_imm = XLEN'($signed(dec_imm32));

    // ---------------- buffer ----------------
    logic [XLEN-1:0] imm_mem [DEPTH];
    logic [2:0]      fmt_mem [DEPTH];
    logic            ill_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             push;
    logic             pop;

    // in_ready looks only at registered occupancy, so a full buffer stays
    // closed for a cycle even when the head is being popped.
    assign bus.in_ready  = (count < DEPTH_C);
    assign bus.out_valid = (count != '0);
    assign push = bus.in_valid & bus.in_ready & ~flush;
    assign pop  = bus.out_valid & bus.out_ready & ~flush;

    always_ff @(posedge clk) begin
        if (push) begin
            imm_mem[wr_ptr] <= dec_imm;
            fmt_mem[wr_ptr] <= dec_fmt;
            ill_mem[wr_ptr] <= dec_ill;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ill_cnt <= '0;
        end else if (push && dec_ill && (ill_cnt != '1)) begin
            ill_cnt <= ill_cnt + 1'b1;
        end
    end

    // Head outputs are forced to zero when nothing is buffered.
    assign bus.imm     = bus.out_valid ? imm_mem[rd_ptr] : '0;
    assign bus.fmt     = bus.out_valid ? fmt_mem[rd_ptr] : 3'd0;
    assign bus.illegal = bus.out_valid ? ill_mem[rd_ptr] : 1'b0;
endmodule

// File: tb/tb_immed_gen_pipe.sv
// Self-checking bench for immed_gen_pipe.
// dut_a: XLEN=32, DEPTH=2, CNT_W=2 (decode, backpressure, flush, reset, counter)
// dut_b: XLEN=64, DEPTH=2, CNT_W=16 (sign extension to 64 bits)
module tb_immed_gen_pipe;
    logic clk;
    logic rst;
    logic flush_a;
    logic flush_b;
    logic [1:0]  ill_cnt_a;
    logic [15:0] ill_cnt_b;

    int checks;
    int failures;

    logic [35:0] exp_q[$];

    immed_gen_pipe_if #(.XLEN(32)) a ();
    immed_gen_pipe_if #(.XLEN(64)) b ();

    immed_gen_pipe #(.XLEN(32), .DEPTH(2), .CNT_W(2)) dut_a (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush_a),
        .bus     (a),
        .ill_cnt (ill_cnt_a)
    );

    immed_gen_pipe #(.XLEN(64), .DEPTH(2), .CNT_W(16)) dut_b (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush_b),
        .bus     (b),
        .ill_cnt (ill_cnt_b)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one word for one cycle; the expectation is queued only if the
    // DUT is ready, i.e. the word is really accepted on the coming edge.
    task automatic push_a(input logic [31:0] word, input logic [35:0] exp);
        a.ir       = word;
        a.in_valid = 1'b1;
        if (a.in_ready) exp_q.push_back(exp);
        tick();
        a.in_valid = 1'b0;
    endtask

    task automatic push_b(input logic [31:0] word);
        b.ir       = word;
        b.in_valid = 1'b1;
        tick();
        b.in_valid = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (!rst && a.out_valid && a.out_ready) begin
            chk("a_q_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                chk("a_out", {28'b0, a.illegal, a.fmt, a.imm}, {28'b0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [1:0]  ill_seq [5];
    logic [11:0] imm12;
    logic [31:0] rnd;

    initial begin
        checks   = 0;
        failures = 0;
        ill_seq  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        rst = 1'b1;
        flush_a = 1'b0;
        flush_b = 1'b0;
        a.ir = '0; a.in_valid = 1'b0; a.out_ready = 1'b0;
        b.ir = '0; b.in_valid = 1'b0; b.out_ready = 1'b0;

        // reset state
        #3;
        chk("rst_out_valid", a.out_valid, 0);
        chk("rst_in_ready",  a.in_ready, 1);
        chk("rst_imm",       a.imm, 0);
        chk("rst_fmt",       a.fmt, 0);
        chk("rst_illegal",   a.illegal, 0);
        chk("rst_ill_cnt",   ill_cnt_a, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        a.out_ready = 1'b1;
        b.out_ready = 1'b1;

        // decode vectors, first push directly after reset
        push_a(32'hFFF00093, {1'b0, 3'd1, 32'hFFFFFFFF});
        chk("latency_out_valid", a.out_valid, 1);
        push_a(32'h12345037, {1'b0, 3'd4, 32'h12345000});
        push_a(32'hFE000EE3, {1'b0, 3'd3, 32'hFFFFFFFC});
        push_a(32'h0080006F, {1'b0, 3'd5, 32'h00000008});
        push_a(32'h00812623, {1'b0, 3'd2, 32'h0000000C});
        push_a(32'h00B50533, {1'b0, 3'd0, 32'h00000000});
        tick();
        chk("idle_out_valid", a.out_valid, 0);
        chk("idle_imm", a.imm, 0);
        chk("idle_fmt", a.fmt, 0);

        // 64-bit sign extension
        push_b(32'h800000B7);
        chk("b_u_imm", b.imm, 64'hFFFFFFFF80000000);
        chk("b_u_fmt", b.fmt, 4);
        push_b(32'hFFF00093);
        chk("b_i_imm", b.imm, 64'hFFFFFFFFFFFFFFFF);
        push_b(32'h12345037);
        chk("b_u_pos_imm", b.imm, 64'h0000000012345000);
        tick();
        chk("b_idle_out_valid", b.out_valid, 0);

        // backpressure
        a.out_ready = 1'b0;
        push_a(32'h00100093, {1'b0, 3'd1, 32'h00000001});
        push_a(32'h12345037, {1'b0, 3'd4, 32'h12345000});
        chk("full_in_ready", a.in_ready, 0);
        chk("full_head_imm", a.imm, 32'h1);
        push_a(32'h0080006F, {1'b0, 3'd5, 32'h00000008});  // refused while full
        chk("stall_head_imm", a.imm, 32'h1);
        chk("stall_head_fmt", a.fmt, 1);
        chk("stall_in_ready", a.in_ready, 0);
        a.out_ready = 1'b1;
        tick();
        chk("after_pop_in_ready", a.in_ready, 1);
        chk("after_pop_head_fmt", a.fmt, 4);
        tick();
        chk("drained_out_valid", a.out_valid, 0);

        // random I-type stream with random backpressure
        for (int i = 0; i < 24; i++) begin
            a.out_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) begin
                imm12 = 12'($urandom_range(0, 4095));
                push_a({imm12, 5'($urandom_range(0, 31)), 3'b000, 5'd1, 7'h13},
                       {1'b0, 3'd1, {{20{imm12[11]}}, imm12}});
            end else begin
                tick();
            end
        end
        a.out_ready = 1'b1;
        repeat (3) tick();
        chk("rand_drained", a.out_valid, 0);
        chk("rand_ill_cnt", ill_cnt_a, 0);

        // flush with two entries buffered
        a.out_ready = 1'b0;
        push_a(32'h0000007F, {1'b1, 3'd0, 32'h0});
        push_a(32'h00812623, {1'b0, 3'd2, 32'h0000000C});
        chk("pre_flush_ill_cnt", ill_cnt_a, 1);
        chk("pre_flush_illegal", a.illegal, 1);
        flush_a = 1'b1;
        a.ir = 32'h0000007F;
        a.in_valid = 1'b1;
        tick();
        flush_a = 1'b0;
        a.in_valid = 1'b0;
        exp_q.delete();
        chk("flush2_out_valid", a.out_valid, 0);
        chk("flush2_ill_cnt", ill_cnt_a, 1);
        chk("flush2_in_ready", a.in_ready, 1);

        // flush with one entry: the same-cycle push is discarded and uncounted
        push_a(32'h0000007F, {1'b1, 3'd0, 32'h0});
        chk("pre_flush1_ill_cnt", ill_cnt_a, 2);
        flush_a = 1'b1;
        a.ir = 32'h0000007F;
        a.in_valid = 1'b1;
        tick();
        flush_a = 1'b0;
        a.in_valid = 1'b0;
        exp_q.delete();
        chk("flush1_out_valid", a.out_valid, 0);
        chk("flush1_ill_cnt", ill_cnt_a, 2);
        tick();
        chk("flush1_stays_empty", a.out_valid, 0);

        // asynchronous reset with one entry buffered
        push_a(32'h0080006F, {1'b0, 3'd5, 32'h00000008});
        chk("pre_rst_out_valid", a.out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out_valid", a.out_valid, 0);
        chk("async_rst_ill_cnt", ill_cnt_a, 0);
        chk("async_rst_imm", a.imm, 0);
        chk("async_rst_in_ready", a.in_ready, 1);
        exp_q.delete();
        #1 rst = 1'b0;
        tick();
        tick();
        chk("post_rst_out_valid", a.out_valid, 0);

        // saturating illegal counter (2 bits)
        a.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            rnd = $urandom;
            push_a({rnd[31:7], 7'h7F}, {1'b1, 3'd0, 32'h0});
            chk("ill_head", a.illegal, 1);
            chk("ill_cnt_seq", ill_cnt_a, ill_seq[k]);
        end
        tick();
        chk("ill_drained", a.out_valid, 0);

        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/immed_gen_pipe.md
IMMED_GEN_PIPE -- requirements
Module: immed_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 or 64.
REQ-002 Parameter DEPTH, default 2, output buffer entries; power of 2, at least 2.
REQ-003 Parameter CNT_W, default 16, illegal-instruction counter width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 flush  input  1  synchronous clear of all buffered entries.
REQ-007 ir  input  32  instruction word.
REQ-008 in_valid  input  1  ir is valid this cycle.
REQ-009 in_ready  output  1  block can accept ir this cycle.
REQ-010 imm  output  XLEN  sign-extended immediate at buffer head.
REQ-011 fmt  output  3  format at head: 0=R/none, 1=I, 2=S, 3=B, 4=U, 5=J.
REQ-012 illegal  output  1  head entry carries an unrecognised opcode.
REQ-013 out_valid  output  1  head entry is valid.
REQ-014 out_ready  input  1  consumer takes the head entry this cycle.
REQ-015 ill_cnt  output  CNT_W  saturating count of accepted illegal opcodes.

Function
REQ-016 Decode on ir[6:0]:
- I format: 0010011, 0000011, 1100111, 1110011.
- S format: 0100011.
- B format: 1100011.
- U format: 0110111, 0010111.
- J format: 1101111.
- R/none: 0110011, with imm=0 and illegal=0.
- Any other opcode: fmt=0, imm=0, illegal=1.
REQ-017 Immediate bit placement, all results sign-extended from ir[31] to XLEN:
- I: ir[31:20].
- S: {ir[31:25], ir[11:7]}.
- B: {ir[31], ir[7], ir[30:25], ir[11:8], 0}.
- U: {ir[31:12], 12 zeros}.
- J: {ir[31], ir[19:12], ir[20], ir[30:21], 0}.
REQ-018 U format with XLEN=64: bits 63:32 equal ir[31].
REQ-019 Accept condition: in_valid and in_ready are both 1 at a rising edge. The decoded entry is written to the buffer on that edge.
REQ-020 Latency is exactly 1 cycle. An entry accepted at edge N appears at the head with out_valid=1 after edge N when the buffer was empty.
REQ-021 Pop condition: out_valid and out_ready are both 1 at a rising edge.
REQ-022 The buffer is FIFO-ordered, with read and write pointers that wrap modulo DEPTH.
REQ-023 in_ready = (occupancy < DEPTH), derived from registered occupancy only. There is no combinational path from out_ready to in_ready. When full, a same-cycle pop does not enable a push.
REQ-024 Simultaneous push and pop with 0 < occupancy < DEPTH leaves occupancy unchanged and preserves order.
REQ-025 When out_valid=0, imm, fmt and illegal are 0.
REQ-026 While out_valid=1 and out_ready=0, imm, fmt and illegal stay stable.
REQ-027 ill_cnt increments by 1 on each accepted entry with illegal=1, and holds at 2^CNT_W-1.
REQ-028 flush=1 at an edge:
- occupancy goes to 0 and pointers reset.
- any push in that same cycle is discarded and not counted.
- ill_cnt is retained.
REQ-029 flush has priority over push and pop.

Reset
REQ-030 While rst=1, asynchronously:
- occupancy=0, pointers=0, out_valid=0, imm=0, fmt=0, illegal=0, ill_cnt=0.
- in_ready=1 (buffer empty).
REQ-031 Reset asserted mid-transfer drops all buffered entries. No entry appears after rst deasserts until a new accept occurs.
REQ-032 The first accept may occur on the first rising edge after rst deasserts.

Verification
REQ-033 Decode vectors, XLEN=32, out_ready=1; each single-cycle push yields the listed output one cycle later:
- ir=0xFFF00093 -> imm=0xFFFFFFFF, fmt=1.
- ir=0x12345037 -> imm=0x12345000, fmt=4.
- ir=0xFE000EE3 -> imm=0xFFFFFFFC, fmt=3.
- ir=0x0080006F -> imm=0x00000008, fmt=5.
REQ-034 Sign extension, XLEN=64: ir=0x800000B7 -> imm=0xFFFFFFFF80000000, fmt=4.
REQ-035 Backpressure, DEPTH=2, out_ready=0:
- push A then B -> in_ready=0 after the second accept, and head stays A.
- raise out_ready -> A, then B emitted on consecutive cycles.
- in_ready returns to 1 one cycle after the first pop.
REQ-036 Illegal count, CNT_W=2: push 5 words with opcode 0x7F -> illegal=1 on each output, ill_cnt sequence 1, 2, 3, 3, 3.
REQ-037 Flush and reset:
- buffer holds 2 entries, flush=1 with in_valid=1 -> out_valid=0 next cycle, ill_cnt unchanged.
- buffer holds 1 entry, rst pulsed between edges -> out_valid=0 and ill_cnt=0 immediately, without waiting for a clock edge.
